// File: rtl/tof_frame_parser_if.sv
// tof_frame_parser_if: byte stream from the UART receiver into the TOF10120
// frame parser, plus the parsed distance / error reporting back out.
// The parser connects through the slave modport; the UART side (or a bench)
// uses the master modport.
interface tof_frame_parser_if #(
    parameter int DIST_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic [DIST_W-1:0] dist_mm;
    logic              dist_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [15:0]       frame_cnt;

    modport master (
        output in_data,
        output in_valid,
        input  dist_mm,
        input  dist_valid,
        input  frame_err,
        input  err_code,
        input  frame_cnt
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output dist_mm,
        output dist_valid,
        output frame_err,
        output err_code,
        output frame_cnt
    );
endinterface

// File: rtl/tof_frame_parser.sv
// tof_frame_parser: parses TOF10120 ASCII distance frames ("1234mm\r\n")
// arriving one byte per in_valid strobe, converts the decimal digits to a
// binary millimetre value and reports malformed frames and inter-byte
// timeouts through a one-cycle frame_err pulse and a held err_code.
// Optional feature macro: TOF_RANGE_CHECK_EN -- when defined, a completed
// frame whose value exceeds MAX_DIST_MM is rejected with err_code 2.
module tof_frame_parser #(
    parameter int DIST_W      = 16,
    parameter int MAX_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 104160,
    parameter int MAX_DIST_MM = 1800
) (
    input  logic clk,
    input  logic rst,
    tof_frame_parser_if.slave bus
);

    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
    localparam int TCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [NDIG_W-1:0] MAX_NDIG = NDIG_W'(MAX_DIGITS);
    localparam logic [TCNT_W-1:0] TO_LAST  = TCNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CH_M  = 8'h6D;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam logic [1:0] ERR_CHAR    = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        DIGITS,
        UNIT2,
        WAIT_CR,
        WAIT_LF
    } state_t;

    state_t            state;
    logic [DIST_W-1:0] acc;
    logic [NDIG_W-1:0] ndig;
    logic [TCNT_W-1:0] tcnt;

    logic              is_digit;
    logic [3:0]        digit_val;
    logic [DIST_W-1:0] acc_next;
    logic              range_ok;
    logic              err_now;
    logic [1:0]        err_kind;
    logic              frame_done;

    assign is_digit  = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    assign digit_val = bus.in_data[3:0];
    assign acc_next  = acc * DIST_W'(10) + DIST_W'(digit_val);

`ifdef TOF_RANGE_CHECK_EN
    assign range_ok = (acc <= DIST_W'(MAX_DIST_MM));
`else
    logic unused_range;
    assign range_ok     = 1'b1;
    assign unused_range = (acc > DIST_W'(MAX_DIST_MM));
`endif

    // Decide whether this cycle ends the frame, either as a good frame or
    // with one of the three error causes; a byte always beats the timeout.
    always_comb begin
        err_now    = 1'b0;
        err_kind   = 2'd0;
        frame_done = 1'b0;
        if (bus.in_valid) begin
            case (state)
                DIGITS: begin
                    if (is_digit) begin
                        if (ndig == MAX_NDIG) begin
                            err_now  = 1'b1;
                            err_kind = ERR_OVF;
                        end
                    end else if (bus.in_data != CH_M) begin
                        err_now  = 1'b1;
                        err_kind = ERR_CHAR;
                    end
                end
                UNIT2: begin
                    if (bus.in_data != CH_M) begin
                        err_now  = 1'b1;
                        err_kind = ERR_CHAR;
                    end
                end
                WAIT_CR: begin
                    if (bus.in_data != CH_CR) begin
                        err_now  = 1'b1;
                        err_kind = ERR_CHAR;
                    end
                end
                WAIT_LF: begin
                    if (bus.in_data != CH_LF) begin
                        err_now  = 1'b1;
                        err_kind = ERR_CHAR;
                    end else if (!range_ok) begin
                        err_now  = 1'b1;
                        err_kind = ERR_OVF;
                    end else begin
                        frame_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if ((state != IDLE) && (tcnt == TO_LAST)) begin
            err_now  = 1'b1;
            err_kind = ERR_TIMEOUT;
        end
    end

    // Frame state machine with registered outputs: errors and completed
    // frames return to IDLE, otherwise each byte advances the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            acc            <= '0;
            ndig           <= '0;
            tcnt           <= '0;
            bus.dist_mm    <= '0;
            bus.dist_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.err_code   <= 2'd0;
            bus.frame_cnt  <= 16'd0;
        end else begin
            bus.dist_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            if (err_now) begin
                bus.frame_err <= 1'b1;
                bus.err_code  <= err_kind;
                state         <= IDLE;
                acc           <= '0;
                ndig          <= '0;
                tcnt          <= '0;
            end else if (frame_done) begin
                bus.dist_mm    <= acc;
                bus.dist_valid <= 1'b1;
                bus.frame_cnt  <= bus.frame_cnt + 16'd1;
                state          <= IDLE;
                acc            <= '0;
                ndig           <= '0;
                tcnt           <= '0;
            end else if (bus.in_valid) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (is_digit) begin
                            acc   <= DIST_W'(digit_val);
                            ndig  <= NDIG_W'(1);
                            state <= DIGITS;
                        end
                    end
                    DIGITS: begin
                        if (is_digit) begin
                            acc  <= acc_next;
                            ndig <= ndig + NDIG_W'(1);
                        end else begin
                            state <= UNIT2;
                        end
                    end
                    UNIT2:   state <= WAIT_CR;
                    WAIT_CR: state <= WAIT_LF;
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tof_frame_parser.sv
// tb_tof_frame_parser: drives byte streams into tof_frame_parser and compares
// pulses and held outputs with a string-matching model of the frame format.
// Honours TOF_RANGE_CHECK_EN the same way the design does.
module tb_tof_frame_parser;

    localparam int DW    = 16;
    localparam int MAXD  = 4;
    localparam int TO    = 200;
    localparam int MAXMM = 1800;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mbuf[$];
    int         m_dist = 0;
    int         m_code = 0;
    int         m_cnt  = 0;

    logic [1:0] obs_q[$];
    int         gap_pulses;

    tof_frame_parser_if #(.DIST_W(DW)) bus ();

    tof_frame_parser #(
        .DIST_W      (DW),
        .MAX_DIGITS  (MAXD),
        .TIMEOUT_CYC (TO),
        .MAX_DIST_MM (MAXMM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic string frame(input string body);
        return $sformatf("%smm%c%c", body, 8'd13, 8'd10);
    endfunction

    // Model: the buffer holds the frame seen so far; returns 0 nothing, 1 good frame, 2 error.
    function automatic int model_byte(input logic [7:0] b);
        logic [7:0] sfx [4];
        int nd;
        int tail;
        int val;
        sfx[0] = 8'h6D; sfx[1] = 8'h6D; sfx[2] = 8'h0D; sfx[3] = 8'h0A;
        if (mbuf.size() == 0) begin
            if (is_dig(b)) mbuf.push_back(b);
            return 0;
        end
        nd = 0;
        while (nd < mbuf.size() && is_dig(mbuf[nd])) nd++;
        tail = mbuf.size() - nd;
        if (tail == 0 && is_dig(b)) begin
            if (nd < MAXD) begin
                mbuf.push_back(b);
                return 0;
            end
            mbuf.delete();
            m_code = 2;
            return 2;
        end
        if (b != sfx[tail]) begin
            mbuf.delete();
            m_code = 1;
            return 2;
        end
        if (tail < 3) begin
            mbuf.push_back(b);
            return 0;
        end
        val = 0;
        for (int i = 0; i < nd; i++) val = val * 10 + (int'(mbuf[i]) - 48);
        mbuf.delete();
`ifdef TOF_RANGE_CHECK_EN
        if (val > MAXMM) begin
            m_code = 2;
            return 2;
        end
`endif
        m_dist = val;
        m_cnt  = (m_cnt + 1) % 65536;
        return 1;
    endfunction

    // Model of n idle cycles: returns the idle cycle index of a timeout error, or 0.
    function automatic int model_idle(input int n);
        if (mbuf.size() != 0 && n >= TO) begin
            mbuf.delete();
            m_code = 3;
            return TO;
        end
        return 0;
    endfunction

    task automatic drive_byte(input logic [7:0] b, output logic dv, output logic fe);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        dv = bus.dist_valid;
        fe = bus.frame_err;
    endtask

    task automatic idle(input int n, output int fe_cnt, output int fe_first, output int dv_cnt);
        fe_cnt = 0; fe_first = 0; dv_cnt = 0;
        for (int j = 1; j <= n; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.frame_err === 1'b1) begin
                if (fe_cnt == 0) fe_first = j;
                fe_cnt++;
            end
            if (bus.dist_valid === 1'b1) dv_cnt++;
        end
    endtask

    task automatic send_str(input string s, input int gap);
        logic dv, fe;
        int fc, ff, dc;
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(s[i], dv, fe);
            obs_q.push_back({dv, fe});
            if (gap > 0) begin
                idle(gap, fc, ff, dc);
                gap_pulses += fc + dc;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.dist_mm !== 16'd0) $display("[TB] FAIL reset_dist: got %0d, want 0", bus.dist_mm); else n_pass++;
        n_checks++;
        if (bus.dist_valid !== 1'b0) $display("[TB] FAIL reset_dv: got %b, want 0", bus.dist_valid); else n_pass++;
        n_checks++;
        if (bus.frame_err !== 1'b0) $display("[TB] FAIL reset_fe: got %b, want 0", bus.frame_err); else n_pass++;
        n_checks++;
        if (bus.err_code !== 2'd0) $display("[TB] FAIL reset_code: got %0d, want 0", bus.err_code); else n_pass++;
        n_checks++;
        if (bus.frame_cnt !== 16'd0) $display("[TB] FAIL reset_cnt: got %0d, want 0", bus.frame_cnt); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        string s;
        int e;
        s = frame("523");
        obs_q.delete(); gap_pulses = 0;
        send_str(s, 30);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL single_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
        n_checks++;
        if (gap_pulses !== 0) $display("[TB] FAIL single_gaps: got %0d pulses, want 0", gap_pulses); else n_pass++;
        n_checks++;
        if (bus.dist_mm !== 16'd523) $display("[TB] FAIL single_dist: got %0d, want 523", bus.dist_mm); else n_pass++;
        n_checks++;
        if (bus.frame_cnt !== 16'd1) $display("[TB] FAIL single_cnt: got %0d, want 1", bus.frame_cnt); else n_pass++;
        n_checks++;
        if (bus.err_code !== 2'd0) $display("[TB] FAIL single_code: got %0d, want 0", bus.err_code); else n_pass++;
    endtask

    task automatic test_back_to_back();
        string s;
        int e;
        s = frame("0");
        obs_q.delete(); gap_pulses = 0;
        send_str(s, 0);
        n_checks++;
        if (bus.dist_mm !== 16'd0) $display("[TB] FAIL b2b_dist0: got %0d, want 0", bus.dist_mm); else n_pass++;
        s = {s, frame("1800")};
        send_str(frame("1800"), 0);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL b2b_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
        n_checks++;
        if (bus.dist_mm !== 16'd1800) $display("[TB] FAIL b2b_dist1800: got %0d, want 1800", bus.dist_mm); else n_pass++;
        n_checks++;
        if (bus.frame_cnt !== 16'(m_cnt)) $display("[TB] FAIL b2b_cnt: got %0d, want %0d", bus.frame_cnt, m_cnt); else n_pass++;
    endtask

    task automatic test_overflow();
        string s;
        int e;
        s = frame("12345");
        obs_q.delete(); gap_pulses = 0;
        send_str(s, 2);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL ovf_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
        n_checks++;
        if (obs_q[4] !== 2'b01) $display("[TB] FAIL ovf_fifth: got dv,fe=%b, want 01", obs_q[4]); else n_pass++;
        n_checks++;
        if (bus.err_code !== 2'd2) $display("[TB] FAIL ovf_code: got %0d, want 2", bus.err_code); else n_pass++;
        n_checks++;
        if (bus.dist_mm !== 16'd1800) $display("[TB] FAIL ovf_dist: got %0d, want 1800", bus.dist_mm); else n_pass++;
    endtask

    task automatic test_bad_char();
        string s;
        int e;
        s = $sformatf("42mx%c%c", 8'd13, 8'd10);
        obs_q.delete(); gap_pulses = 0;
        send_str(s, 1);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL bad_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
        n_checks++;
        if (bus.err_code !== 2'd1) $display("[TB] FAIL bad_code: got %0d, want 1", bus.err_code); else n_pass++;
    endtask

    task automatic test_timeout();
        int e, we, fc, ff, dc;
        string s;
        s = "12m";
        obs_q.delete(); gap_pulses = 0;
        send_str(s, 0);
        for (int i = 0; i < s.len(); i++) e = model_byte(s[i]);
        we = model_idle(TO + 5);
        idle(TO + 5, fc, ff, dc);
        n_checks++;
        if (ff !== we || fc !== 1) $display("[TB] FAIL timeout_pulse: got %0d pulses first at %0d, want 1 at %0d", fc, ff, we); else n_pass++;
        n_checks++;
        if (bus.err_code !== 2'd3) $display("[TB] FAIL timeout_code: got %0d, want 3", bus.err_code); else n_pass++;
        s = frame("77");
        obs_q.delete();
        send_str(s, 3);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL after_to_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
        n_checks++;
        if (bus.dist_mm !== 16'd77) $display("[TB] FAIL after_to_dist: got %0d, want 77", bus.dist_mm); else n_pass++;
        n_checks++;
        if (bus.err_code !== 2'd3) $display("[TB] FAIL after_to_code: got %0d, want 3", bus.err_code); else n_pass++;
    endtask

    task automatic test_timeout_boundary();
        int e, fc, ff, dc;
        string s;
        s = frame("12");
        obs_q.delete(); gap_pulses = 0;
        send_str("12", 0);
        idle(TO - 1, fc, ff, dc);
        n_checks++;
        if (fc + dc !== model_idle(TO - 1)) $display("[TB] FAIL edge_gap: got %0d pulses, want 0", fc + dc); else n_pass++;
        send_str(s.substr(2, s.len() - 1), 0);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL edge_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
        n_checks++;
        if (bus.dist_mm !== 16'd12) $display("[TB] FAIL edge_dist: got %0d, want 12", bus.dist_mm); else n_pass++;
    endtask

    task automatic test_range();
        string s;
        int e;
        s = {frame("1801"), frame("1800")};
        obs_q.delete(); gap_pulses = 0;
        send_str(s, 1);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL range_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
`ifdef TOF_RANGE_CHECK_EN
        n_checks++;
        if (obs_q[7] !== 2'b01) $display("[TB] FAIL range_1801: got dv,fe=%b, want 01", obs_q[7]); else n_pass++;
`else
        n_checks++;
        if (obs_q[7] !== 2'b10) $display("[TB] FAIL range_1801: got dv,fe=%b, want 10", obs_q[7]); else n_pass++;
`endif
        n_checks++;
        if (bus.dist_mm !== 16'd1800) $display("[TB] FAIL range_dist: got %0d, want 1800", bus.dist_mm); else n_pass++;
        n_checks++;
        if (bus.err_code !== 2'(m_code)) $display("[TB] FAIL range_code: got %0d, want %0d", bus.err_code, m_code); else n_pass++;
        n_checks++;
        if (bus.frame_cnt !== 16'(m_cnt)) $display("[TB] FAIL range_cnt: got %0d, want %0d", bus.frame_cnt, m_cnt); else n_pass++;
    endtask

    task automatic test_random();
        string s;
        int nd, cut, gap, e, we, fc, ff, dc;
        logic dv, fe;
        logic [7:0] b;
        for (int f = 0; f < 40; f++) begin
            nd = $urandom_range(1, 5);
            s = "";
            for (int k = 0; k < nd; k++) s = $sformatf("%s%c", s, 8'(8'h30 + $urandom_range(0, 9)));
            s = frame(s);
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(1, 255));
                s[$urandom_range(0, s.len() - 1)] = b;
            end
            cut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, s.len() - 1) : -1;
            for (int i = 0; i < s.len(); i++) begin
                e = model_byte(s[i]);
                drive_byte(s[i], dv, fe);
                n_checks++;
                if ({dv, fe} !== {e == 1, e == 2})
                    $display("[TB] FAIL rnd_f%0d_b%0d: got dv,fe=%b%b, want %b", f, i, dv, fe, {e == 1, e == 2});
                else n_pass++;
                gap = (i == cut) ? TO + 2 : $urandom_range(0, 3);
                if (gap > 0) begin
                    we = model_idle(gap);
                    idle(gap, fc, ff, dc);
                    n_checks++;
                    if (ff !== we || fc !== (we != 0 ? 1 : 0) || dc !== 0)
                        $display("[TB] FAIL rnd_gap_f%0d_b%0d: got fe %0d at %0d dv %0d, want fe at %0d", f, i, fc, ff, dc, we);
                    else n_pass++;
                end
            end
        end
        we = model_idle(TO + 2);
        idle(TO + 2, fc, ff, dc);
        n_checks++;
        if (ff !== we || dc !== 0) $display("[TB] FAIL rnd_flush: got fe at %0d dv %0d, want fe at %0d", ff, dc, we); else n_pass++;
        n_checks++;
        if (bus.dist_mm !== 16'(m_dist)) $display("[TB] FAIL rnd_dist: got %0d, want %0d", bus.dist_mm, m_dist); else n_pass++;
        n_checks++;
        if (bus.err_code !== 2'(m_code)) $display("[TB] FAIL rnd_code: got %0d, want %0d", bus.err_code, m_code); else n_pass++;
        n_checks++;
        if (bus.frame_cnt !== 16'(m_cnt)) $display("[TB] FAIL rnd_cnt: got %0d, want %0d", bus.frame_cnt, m_cnt); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int e, fc, ff, dc;
        string s;
        obs_q.delete(); gap_pulses = 0;
        send_str("99m", 1);
        rst = 1'b0;
        #1;
        mbuf.delete();
        m_dist = 0; m_code = 0; m_cnt = 0;
        n_checks++;
        if ({bus.dist_mm, bus.dist_valid, bus.frame_err, bus.err_code, bus.frame_cnt} !== 36'd0)
            $display("[TB] FAIL midrst_outputs: got dist=%0d dv=%b fe=%b code=%0d cnt=%0d, want all 0",
                     bus.dist_mm, bus.dist_valid, bus.frame_err, bus.err_code, bus.frame_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        s = $sformatf("m%c%c", 8'd13, 8'd10);
        send_str(s, 0);
        idle(TO + 2, fc, ff, dc);
        for (int i = 0; i < s.len(); i++) begin
            e = model_byte(s[i]);
            n_checks++;
            if (obs_q[i] !== {e == 1, e == 2})
                $display("[TB] FAIL midrst_byte%0d: got dv,fe=%b, want %b", i, obs_q[i], {e == 1, e == 2});
            else n_pass++;
        end
        n_checks++;
        if (fc + dc !== 0) $display("[TB] FAIL midrst_idle: got %0d pulses, want 0", fc + dc); else n_pass++;
        obs_q.delete();
        send_str(frame("55"), 0);
        n_checks++;
        if (bus.dist_mm !== 16'd55 || bus.frame_cnt !== 16'd1)
            $display("[TB] FAIL midrst_next: got dist=%0d cnt=%0d, want 55 and 1", bus.dist_mm, bus.frame_cnt);
        else n_pass++;
    endtask

    // Sequence of scenarios followed by the single summary line.
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_bad_char();
        test_timeout();
        test_timeout_boundary();
        test_range();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Bound on total run time so a stuck run still ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
